// File: rtl/norm_pkg.sv
// Shared definitions for the normalizer and the barrel shifter it pairs with:
// state encoding, shift-direction encoding and the default data width.
package norm_pkg;

  localparam int unsigned W_DEFAULT = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/norm8_seq.sv
// Iterative normalizer: shifts a word one bit per cycle until the chosen end
// bit is set, then presents the shifted word and shift count to the consumer.
module norm8_seq
  import norm_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic                  in_dir,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic [$clog2(W)-1:0]  out_cnt,
  output logic                  out_zero,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(W);

  state_e           state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             target_bit;

  assign target_bit = (dir_q == DIR_RIGHT) ? work_q[0] : work_q[W-1];

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          work_d     = in_data;
          cnt_d      = '0;
          dir_d      = in_dir;
          in_ready_d = 1'b0;
          if (in_data == '0) begin
            zero_d      = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (target_bit) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          work_d = (dir_q == DIR_RIGHT) ? (work_q >> 1) : (work_q << 1);
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_LEFT;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign out_cnt   = cnt_q;
  assign out_zero  = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_norm8_seq.sv
// Directed and random checks of norm8_seq against hand-computed results and a
// small leading/trailing-zero model.
module tb_norm8_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_cnt;
  logic       out_zero;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  norm8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a word, measure edges until out_valid, check the result, hand it off
  task automatic run_word(input logic [7:0] d, input logic dir, input logic [7:0] exp_data,
                          input int exp_cnt, input logic exp_zero, input int exp_lat);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    step();
    in_valid = 1'b0;
    in_dir   = ~dir;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("out_cnt", 32'(out_cnt), 32'(exp_cnt));
    check("out_zero", 32'(out_zero), 32'(exp_zero));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
    check("busy_after_take", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       dir;
    int         k;
    int         w;
    logic [7:0] exp_d;
    logic [7:0] back;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    step();
    check("in_ready_first_edge", 32'(in_ready), 32'd1);

    run_word(8'h13, 1'b0, 8'h98, 3, 1'b0, 4);
    run_word(8'h28, 1'b1, 8'h05, 3, 1'b0, 4);
    run_word(8'h80, 1'b0, 8'h80, 0, 1'b0, 1);
    run_word(8'h01, 1'b1, 8'h01, 0, 1'b0, 1);
    run_word(8'h00, 1'b0, 8'h00, 0, 1'b1, 0);
    run_word(8'h00, 1'b1, 8'h00, 0, 1'b1, 0);
    run_word(8'h80, 1'b1, 8'h01, 7, 1'b0, 8);

    // Worst-case word with the consumer stalling
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_dir   = 1'b0;
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("stall_latency", 32'(k), 32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'h55;
      step();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h80);
      check("stall_out_cnt", 32'(out_cnt), 32'd7);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of shifting discards the word
    in_valid = 1'b1;
    in_data  = 8'h02;
    in_dir   = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_cnt", 32'(out_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd0);
    step();
    check("mid_rel_first_edge", 32'(in_ready), 32'd1);
    run_word(8'h40, 1'b0, 8'h80, 1, 1'b0, 2);

    // Random words against a zero-count model
    for (int n = 0; n < 500; n++) begin
      d   = 8'($urandom_range(0, 255));
      dir = 1'($urandom_range(0, 1));
      k = 0;
      if (d != 8'h00) begin
        if (dir == 1'b0) begin
          while (d[7 - k] == 1'b0) k++;
          exp_d = d << k;
        end else begin
          while (d[k] == 1'b0) k++;
          exp_d = d >> k;
        end
      end else begin
        exp_d = 8'h00;
      end
      w = 0;
      while (!in_ready && w < 20) begin
        step();
        w++;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_dir   = dir;
      step();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin
        step();
        w++;
      end
      check("rnd_out_valid", 32'(out_valid), 32'd1);
      check("rnd_out_data", 32'(out_data), 32'(exp_d));
      check("rnd_out_cnt", 32'(out_cnt), 32'(k));
      check("rnd_out_zero", 32'(out_zero), 32'(d == 8'h00));
      back = (dir == 1'b0) ? (out_data >> out_cnt) : (out_data << out_cnt);
      check("rnd_restore", 32'(back), 32'(d));
      w = 0;
      while (out_valid && w < 40) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        w++;
      end
      out_ready = 1'b0;
      check("rnd_released", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
